// File: rtl/rsa_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_uart_ctrl_if
//  Brief    : Avalon-MM bus between the RSA controller and the UART core.
//  Revision : 1.0
// ============================================================================
interface rsa_uart_ctrl_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/rsa_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_uart_ctrl
//  Brief    : Avalon-MM master feeding n, d and ciphertext blocks from a UART
//             into the modexp engine and streaming the results back out.
//  Revision : 1.0
// ============================================================================
module rsa_uart_ctrl #(
    parameter logic [4:0] RX_ADDR    = 5'd0,
    parameter logic [4:0] TX_ADDR    = 5'd4,
    parameter logic [4:0] STAT_ADDR  = 5'd8,
    parameter int         RX_RDY_BIT = 7,
    parameter int         TX_RDY_BIT = 6,
    parameter int         IN_BYTES   = 32,
    parameter int         OUT_BYTES  = 31,
    parameter int         GUARD      = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rsa_uart_ctrl_if.master     avm,
    output logic                core_start,
    output logic [255:0]        core_a1,
    output logic [255:0]        core_a2,
    output logic [255:0]        core_a3,
    input  wire logic [255:0]   core_a0,
    input  wire logic           core_done
);
    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic [2:0] {
        S_Q_RX  = 3'd0,
        S_RX    = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_Q_TX  = 3'd4,
        S_TX    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        F_N   = 2'd0,
        F_D   = 2'd1,
        F_ENC = 2'd2
    } field_t;

    state_t          r_state, w_state_nxt;
    field_t          r_field, w_field_nxt;
    logic [5:0]      r_cnt, w_cnt_nxt;
    logic [GW-1:0]   r_guard, w_guard_nxt;
    logic            r_read, w_read_nxt;
    logic            r_write, w_write_nxt;
    logic [4:0]      r_addr, w_addr_nxt;
    logic [31:0]     r_wdata, w_wdata_nxt;
    logic            w_shift, w_capture;
    logic [255:0]    r_n, r_d, r_enc, r_dec;
    logic [4:0]      w_tx_idx;
    logic [7:0]      w_tx_byte;
    logic [7:0]      w_rx_byte;
    logic            w_acc;

    assign w_acc     = ~avm.avm_waitrequest;
    assign w_rx_byte = avm.avm_readdata[7:0];
    // Byte k of a block is dec[8*(30-k) +: 8]; the top byte is never sent.
    assign w_tx_idx  = 5'(OUT_BYTES - 1) - r_cnt[4:0];
    assign w_tx_byte = r_dec[{w_tx_idx, 3'b000} +: 8];

    assign avm.avm_address   = r_addr;
    assign avm.avm_read      = r_read;
    assign avm.avm_write     = r_write;
    assign avm.avm_writedata = r_wdata;
    assign core_start        = (r_state == S_START);
    assign core_a1           = r_enc;
    assign core_a2           = r_d;
    assign core_a3           = r_n;

    always_comb begin
        w_state_nxt = r_state;
        w_field_nxt = r_field;
        w_cnt_nxt   = r_cnt;
        w_guard_nxt = r_guard;
        w_read_nxt  = r_read;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        // A request raised here is seen by the slave next cycle; after it is
        // accepted the request drops, giving the mandatory idle cycle.
        case (r_state)
            S_Q_RX: begin
                if (!r_read) begin
                    w_read_nxt = 1'b1;
                    w_addr_nxt = STAT_ADDR;
                end else if (w_acc) begin
                    w_read_nxt = 1'b0;
                    if (avm.avm_readdata[RX_RDY_BIT]) w_state_nxt = S_RX;
                end
            end
            S_RX: begin
                if (!r_read) begin
                    w_read_nxt = 1'b1;
                    w_addr_nxt = RX_ADDR;
                end else if (w_acc) begin
                    w_read_nxt  = 1'b0;
                    w_shift     = 1'b1;
                    w_state_nxt = S_Q_RX;
                    if (r_cnt == 6'(IN_BYTES - 1)) begin
                        w_cnt_nxt = '0;
                        case (r_field)
                            F_N:     w_field_nxt = F_D;
                            F_D:     w_field_nxt = F_ENC;
                            default: w_state_nxt = S_START;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
                w_guard_nxt = '0;
            end
            S_WAIT: begin
                if (r_guard != GW'(GUARD)) begin
                    w_guard_nxt = r_guard + 1'b1;
                end else if (core_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_Q_TX;
                end
            end
            S_Q_TX: begin
                if (!r_read) begin
                    w_read_nxt = 1'b1;
                    w_addr_nxt = STAT_ADDR;
                end else if (w_acc) begin
                    w_read_nxt = 1'b0;
                    if (avm.avm_readdata[TX_RDY_BIT]) w_state_nxt = S_TX;
                end
            end
            S_TX: begin
                if (!r_write) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = TX_ADDR;
                    w_wdata_nxt = {24'd0, w_tx_byte};
                end else if (w_acc) begin
                    w_write_nxt = 1'b0;
                    w_state_nxt = S_Q_TX;
                    if (r_cnt == 6'(OUT_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_field_nxt = F_ENC;
                        w_state_nxt = S_Q_RX;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_Q_RX;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_Q_RX;
            r_field <= F_N;
            r_cnt   <= '0;
            r_guard <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= STAT_ADDR;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_field <= w_field_nxt;
            r_cnt   <= w_cnt_nxt;
            r_guard <= w_guard_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= '0;
            r_d   <= '0;
            r_enc <= '0;
            r_dec <= '0;
        end else begin
            if (w_shift) begin
                case (r_field)
                    F_N:     r_n   <= {r_n[247:0], w_rx_byte};
                    F_D:     r_d   <= {r_d[247:0], w_rx_byte};
                    default: r_enc <= {r_enc[247:0], w_rx_byte};
                endcase
            end
            if (w_capture) r_dec <= core_a0;
        end
    end
endmodule
`default_nettype wire
